// File: rtl/pci_mon_pkg.sv
// pci_mon_pkg: shared constants, capture record layout and saturating add for the PCIe monitor tap
package pci_mon_pkg;

    localparam int CH_ID_WIDTH = 8;

    localparam int CH_CQ = 0;
    localparam int CH_CC = 1;
    localparam int CH_RQ = 2;
    localparam int CH_RC = 3;

    localparam int HDR_LSB = 0;

    // Channel id sits directly above the header bits
    function automatic int ch_lsb(input int hdr_w);
        return hdr_w;
    endfunction

    // Timestamp occupies the top of the record
    function automatic int ts_lsb(input int hdr_w);
        return hdr_w + CH_ID_WIDTH;
    endfunction

    // Add d to v, clamping at the all-ones value of a w-bit counter
    function automatic logic [63:0] sat_add(input logic [63:0] v, input logic [63:0] d, input int w);
        logic [64:0] s;
        logic [63:0] mx;
        mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s  = {1'b0, v} + {1'b0, d};
        return (s > {1'b0, mx}) ? mx : s[63:0];
    endfunction

endpackage

// File: rtl/pci_mon_cap_fifo.sv
// pci_mon_cap_fifo: first-word-fall-through FIFO holding captured header records
module pci_mon_cap_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr, rd;
    logic         do_push, do_pop;

    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign valid   = wr != rd;
    assign dout    = mem[rd[AW-1:0]];
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);

    // Wrap-bit pointers; a pop while full frees the slot the push lands in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
        end
    end

    // Record storage needs no reset; only pointers define occupancy
    always_ff @(posedge clk) begin
        if (do_push) mem[wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pci_mon_tap.sv
// pci_mon_tap: zero-latency AXI4-Stream pass-through with per-channel statistics and header capture
module pci_mon_tap
    import pci_mon_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int C_DATA_WIDTH = 512,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
    parameter int TUSER_WIDTH  = 183,
    parameter int CNT_WIDTH    = 32,
    parameter int HDR_WIDTH    = 128,
    parameter int TS_WIDTH     = 32,
    parameter int CAP_DEPTH    = 16
) (
    input  logic                                  user_clk,
    input  logic                                  reset,
    input  logic [NUM_CH-1:0]                     s_tvalid,
    input  logic [NUM_CH*C_DATA_WIDTH-1:0]        s_tdata,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]          s_tkeep,
    input  logic [NUM_CH-1:0]                     s_tlast,
    input  logic [NUM_CH*TUSER_WIDTH-1:0]         s_tuser,
    output logic [NUM_CH-1:0]                     s_tready,
    output logic [NUM_CH-1:0]                     m_tvalid,
    output logic [NUM_CH*C_DATA_WIDTH-1:0]        m_tdata,
    output logic [NUM_CH*KEEP_WIDTH-1:0]          m_tkeep,
    output logic [NUM_CH-1:0]                     m_tlast,
    output logic [NUM_CH*TUSER_WIDTH-1:0]         m_tuser,
    input  logic [NUM_CH-1:0]                     m_tready,
    input  logic                                  mon_enable,
    input  logic                                  mon_clear,
    input  logic [NUM_CH-1:0]                     cap_ch_mask,
    output logic [NUM_CH*CNT_WIDTH-1:0]           pkt_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]           beat_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]           stall_cnt,
    output logic [CNT_WIDTH-1:0]                  drop_cnt,
    output logic                                  cap_overflow,
    output logic                                  cap_tvalid,
    output logic [HDR_WIDTH+TS_WIDTH+CH_ID_WIDTH-1:0] cap_tdata,
    input  logic                                  cap_tready
);

    localparam int REC_W  = HDR_WIDTH + TS_WIDTH + CH_ID_WIDTH;
    localparam int TS_LSB = ts_lsb(HDR_WIDTH);
    localparam int CH_LSB = ch_lsb(HDR_WIDTH);

    assign m_tvalid = s_tvalid;
    assign m_tdata  = s_tdata;
    assign m_tkeep  = s_tkeep;
    assign m_tlast  = s_tlast;
    assign m_tuser  = s_tuser;
    assign s_tready = m_tready;

    logic [NUM_CH-1:0]    hs, in_pkt, sop, cand;
    logic [TS_WIDTH-1:0]  ts;
    logic [CH_ID_WIDTH-1:0] win;
    logic [HDR_WIDTH-1:0] hdr;
    logic [15:0]          pc, drop_add;
    logic [REC_W-1:0]     rec;
    logic                 full, push;

    assign hs   = s_tvalid & m_tready;
    assign sop  = hs & ~in_pkt;
    assign cand = sop & cap_ch_mask & {NUM_CH{mon_enable}};

    // Packet framing runs regardless of mon_enable so SOP stays correct after re-enable
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) in_pkt <= '0;
        else in_pkt <= (in_pkt & ~(hs & s_tlast)) | (hs & ~s_tlast);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] pkt, beat, stall;
        // Per-channel saturating statistics; clear wins over a same-cycle event
        always_ff @(posedge user_clk or posedge reset) begin
            if (reset || mon_clear) begin
                pkt   <= '0;
                beat  <= '0;
                stall <= '0;
            end else if (mon_enable) begin
                pkt   <= CNT_WIDTH'(sat_add(64'(pkt), 64'(hs[i] & s_tlast[i]), CNT_WIDTH));
                beat  <= CNT_WIDTH'(sat_add(64'(beat), 64'(hs[i]), CNT_WIDTH));
                stall <= CNT_WIDTH'(sat_add(64'(stall), 64'(s_tvalid[i] & ~m_tready[i]), CNT_WIDTH));
            end
        end
        assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]   = pkt;
        assign beat_cnt[i*CNT_WIDTH +: CNT_WIDTH]  = beat;
        assign stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] = stall;
    end

    // Lowest-index candidate wins; count all candidates to size the drop
    always_comb begin
        win = '0;
        hdr = '0;
        pc  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            pc  = pc + 16'(cand[k]);
            win = cand[k] ? CH_ID_WIDTH'(k) : win;
            hdr = cand[k] ? s_tdata[k*C_DATA_WIDTH +: HDR_WIDTH] : hdr;
        end
    end

    assign push     = |cand & (~full | (cap_tvalid & cap_tready));
    assign drop_add = push ? pc - 16'd1 : pc;

    always_comb begin
        rec = '0;
        rec[TS_LSB +: TS_WIDTH]    = ts;
        rec[CH_LSB +: CH_ID_WIDTH] = win;
        rec[HDR_LSB +: HDR_WIDTH]  = hdr;
    end

    // Timestamp, drop counter and sticky overflow; clear zeroes all three
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset || mon_clear) begin
            ts           <= '0;
            drop_cnt     <= '0;
            cap_overflow <= 1'b0;
        end else begin
            ts           <= ts + 1'b1;
            drop_cnt     <= CNT_WIDTH'(sat_add(64'(drop_cnt), 64'(drop_add), CNT_WIDTH));
            cap_overflow <= cap_overflow | (drop_add != 16'd0);
        end
    end

    pci_mon_cap_fifo #(
        .W     (REC_W),
        .DEPTH (CAP_DEPTH)
    ) u_fifo (
        .clk   (user_clk),
        .rst   (reset),
        .push  (push),
        .din   (rec),
        .full  (full),
        .pop   (cap_tready),
        .valid (cap_tvalid),
        .dout  (cap_tdata)
    );

endmodule

// File: tb/tb_pci_mon_tap.sv
// tb_pci_mon_tap: scoreboard bench for the monitor tap pass-through, counters and capture FIFO
module tb_pci_mon_tap;

    localparam int NC = 4, DW = 64, KW = 2, UW = 8, CW = 4, HW = 32, TW = 32, RW = 72;

    logic               user_clk = 0, reset = 1;
    logic [NC-1:0]      s_tvalid = 0, s_tlast = 0, s_tready, m_tvalid, m_tlast, m_tready = '1;
    logic [NC*DW-1:0]   s_tdata = 0, m_tdata;
    logic [NC*KW-1:0]   s_tkeep = 0, m_tkeep;
    logic [NC*UW-1:0]   s_tuser = 0, m_tuser;
    logic               mon_enable = 1, mon_clear = 0, cap_tready = 1;
    logic [NC-1:0]      cap_ch_mask = '1;
    logic [NC*CW-1:0]   pkt_cnt, beat_cnt, stall_cnt;
    logic [CW-1:0]      drop_cnt;
    logic               cap_overflow, cap_tvalid;
    logic [RW-1:0]      cap_tdata;

    int checks = 0, errors = 0;
    logic [RW-1:0] q[$];
    logic [TW-1:0] ts_m;

    pci_mon_tap #(
        .NUM_CH(NC), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TUSER_WIDTH(UW),
        .CNT_WIDTH(CW), .HDR_WIDTH(HW), .TS_WIDTH(TW), .CAP_DEPTH(16)
    ) dut (
        .user_clk(user_clk), .reset(reset),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tready(m_tready),
        .mon_enable(mon_enable), .mon_clear(mon_clear), .cap_ch_mask(cap_ch_mask),
        .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt),
        .drop_cnt(drop_cnt), .cap_overflow(cap_overflow),
        .cap_tvalid(cap_tvalid), .cap_tdata(cap_tdata), .cap_tready(cap_tready)
    );

    always #5 user_clk = ~user_clk;

    // Reference timestamp: counts cycles since reset or the last clear
    always @(posedge user_clk or posedge reset) begin
        if (reset) ts_m <= '0;
        else if (mon_clear) ts_m <= '0;
        else ts_m <= ts_m + 1;
    end

    // Monitor: pass-through every cycle, and capture records against the scoreboard
    always @(negedge user_clk) begin
        checks++;
        if (m_tvalid !== s_tvalid || m_tdata !== s_tdata || m_tkeep !== s_tkeep ||
            m_tlast !== s_tlast || m_tuser !== s_tuser || s_tready !== m_tready) begin
            errors++;
            $display("FAIL passthru: m_tvalid=%h s_tvalid=%h m_tlast=%h s_tlast=%h s_tready=%h m_tready=%h",
                     m_tvalid, s_tvalid, m_tlast, s_tlast, s_tready, m_tready);
        end
        if (cap_tvalid && cap_tready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL cap_rec: unexpected record %h, none expected", cap_tdata);
            end else begin
                logic [RW-1:0] e;
                e = q.pop_front();
                if (cap_tdata !== e) begin
                    errors++;
                    $display("FAIL cap_rec: got %h expected %h", cap_tdata, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    task automatic clr();
        mon_clear = 1;
        step();
        mon_clear = 0;
    endtask

    task automatic send_pkt(input int ch, input int n, input logic [31:0] base, input int stall, input bit cap);
        s_tvalid[ch] = 1;
        s_tdata[ch*DW +: DW] = {32'hC0DE0000 + ch, base};
        m_tready[ch] = 0;
        repeat (stall) step();
        m_tready[ch] = 1;
        for (int b = 0; b < n; b++) begin
            s_tdata[ch*DW +: DW] = {32'hC0DE0000 + ch, base + b};
            s_tlast[ch] = (b == n - 1);
            if (b == 0 && cap) q.push_back({ts_m, 8'(ch), base});
            step();
        end
        s_tvalid[ch] = 0;
        s_tlast[ch] = 0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 100 && q.size() != 0; i++) step();
        chk(name, 64'(q.size()), 64'd0);
    endtask

    initial begin
        // Random traffic under reset, then with monitoring disabled
        for (int c = 0; c < 40; c++) begin
            if (c == 20) begin
                chk("rst_beat", 64'(beat_cnt), 64'd0);
                chk("rst_cap_tvalid", 64'(cap_tvalid), 64'd0);
                reset = 0;
                mon_enable = 0;
            end
            s_tvalid = 4'($urandom);
            s_tlast  = 4'($urandom);
            m_tready = 4'($urandom);
            s_tkeep  = 8'($urandom);
            s_tuser  = $urandom;
            for (int k = 0; k < NC * DW / 32; k++) s_tdata[k*32 +: 32] = $urandom;
            step();
        end
        s_tvalid = 0; s_tlast = 0; m_tready = '1; s_tdata = 0; s_tkeep = 0; s_tuser = 0;
        reset = 1;
        step();
        reset = 0;
        mon_enable = 1;
        step();
        chk("reset_pkt", 64'(pkt_cnt), 64'd0);
        chk("reset_beat", 64'(beat_cnt), 64'd0);
        chk("reset_stall", 64'(stall_cnt), 64'd0);
        chk("reset_drop", 64'(drop_cnt), 64'd0);
        chk("reset_ovf", 64'(cap_overflow), 64'd0);
        chk("reset_cap_tvalid", 64'(cap_tvalid), 64'd0);

        // Counting on ch2: three 4-beat packets, first one stalled 5 cycles
        cap_ch_mask = 4'b0100;
        send_pkt(2, 4, 32'h2000, 5, 1);
        send_pkt(2, 4, 32'h2100, 0, 1);
        send_pkt(2, 4, 32'h2200, 0, 1);
        step(2);
        chk("cnt_pkt2", 64'(pkt_cnt[2*CW +: CW]), 64'd3);
        chk("cnt_beat2", 64'(beat_cnt[2*CW +: CW]), 64'd12);
        chk("cnt_stall2", 64'(stall_cnt[2*CW +: CW]), 64'd5);
        chk("cnt_pkt_other", 64'({pkt_cnt[3*CW +: CW], pkt_cnt[0 +: 2*CW]}), 64'd0);
        chk("cnt_beat_other", 64'({beat_cnt[3*CW +: CW], beat_cnt[0 +: 2*CW]}), 64'd0);
        chk("cnt_stall_other", 64'({stall_cnt[3*CW +: CW], stall_cnt[0 +: 2*CW]}), 64'd0);
        chk("cnt_drop", 64'(drop_cnt), 64'd0);
        wait_empty("cnt_drain");

        // Arbitration: simultaneous SOP on ch1 and ch3
        clr();
        cap_ch_mask = 4'b1111;
        s_tvalid = 4'b1010;
        s_tlast  = 4'b1010;
        s_tdata[1*DW +: DW] = 64'h0000_0001_1111_0001;
        s_tdata[3*DW +: DW] = 64'h0000_0003_3333_0003;
        q.push_back({ts_m, 8'd1, 32'h1111_0001});
        step();
        s_tvalid = 0;
        s_tlast  = 0;
        step();
        chk("arb_drop", 64'(drop_cnt), 64'd1);
        chk("arb_ovf", 64'(cap_overflow), 64'd1);
        wait_empty("arb_drain");

        // Full FIFO: 17 single-beat packets on ch0 with consumer stalled
        clr();
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_ovf", 64'(cap_overflow), 64'd0);
        cap_tready = 0;
        cap_ch_mask = 4'b0001;
        for (int p = 0; p < 17; p++) send_pkt(0, 1, 32'h0A00 + p, 0, p < 16);
        step();
        chk("full_drop", 64'(drop_cnt), 64'd1);
        chk("full_ovf", 64'(cap_overflow), 64'd1);
        chk("full_valid", 64'(cap_tvalid), 64'd1);
        checks++;
        if (cap_tdata !== q[0]) begin
            errors++;
            $display("FAIL full_hold: got %h expected %h", cap_tdata, q[0]);
        end
        step(3);
        checks++;
        if (cap_tdata !== q[0]) begin
            errors++;
            $display("FAIL full_stable: got %h expected %h", cap_tdata, q[0]);
        end
        cap_tready = 1;
        wait_empty("full_drain");
        chk("full_empty", 64'(cap_tvalid), 64'd0);

        // Saturation then clear colliding with a beat
        clr();
        cap_ch_mask = 0;
        send_pkt(0, 20, 32'h5000, 0, 0);
        step();
        chk("sat_beat0", 64'(beat_cnt[0 +: CW]), 64'd15);
        chk("sat_pkt0", 64'(pkt_cnt[0 +: CW]), 64'd1);
        mon_clear = 1;
        s_tvalid[0] = 1;
        s_tlast[0] = 1;
        step();
        mon_clear = 0;
        s_tvalid[0] = 0;
        s_tlast[0] = 0;
        chk("clr_beat0", 64'(beat_cnt[0 +: CW]), 64'd0);
        chk("clr_pkt0", 64'(pkt_cnt[0 +: CW]), 64'd0);
        step();
        chk("clr_beat0_hold", 64'(beat_cnt[0 +: CW]), 64'd0);

        // Masked channel: counted but not captured
        clr();
        cap_ch_mask = 0;
        send_pkt(1, 2, 32'h6000, 0, 0);
        send_pkt(1, 2, 32'h6100, 0, 0);
        step(2);
        chk("mask_pkt1", 64'(pkt_cnt[CW +: CW]), 64'd2);
        chk("mask_beat1", 64'(beat_cnt[CW +: CW]), 64'd4);
        chk("mask_capv", 64'(cap_tvalid), 64'd0);
        // Monitoring disabled: nothing counted or captured
        cap_ch_mask = '1;
        mon_enable = 0;
        send_pkt(1, 2, 32'h6200, 0, 0);
        send_pkt(1, 2, 32'h6300, 0, 0);
        step(2);
        chk("dis_pkt1", 64'(pkt_cnt[CW +: CW]), 64'd2);
        chk("dis_beat1", 64'(beat_cnt[CW +: CW]), 64'd4);
        chk("dis_drop", 64'(drop_cnt), 64'd0);
        chk("dis_capv", 64'(cap_tvalid), 64'd0);

        // Reset mid-packet: next single beat is a fresh SOP
        mon_enable = 1;
        s_tvalid[2] = 1;
        s_tdata[2*DW +: DW] = 64'h0000_0002_7777_0000;
        q.push_back({ts_m, 8'd2, 32'h7777_0000});
        step();
        s_tvalid[2] = 0;
        step(3);
        chk("mid_drained", 64'(q.size()), 64'd0);
        reset = 1;
        step();
        reset = 0;
        step();
        send_pkt(2, 1, 32'h7800, 0, 1);
        step(2);
        chk("mid_pkt2", 64'(pkt_cnt[2*CW +: CW]), 64'd1);
        chk("mid_beat2", 64'(beat_cnt[2*CW +: CW]), 64'd1);
        wait_empty("mid_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
